// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator front-end definitions
//
// Contents:
//   KEY_* constants : 4-bit codes for the non-digit keys
//   kp_state_t      : keypad encoder FSM states
//   key_code()      : row/column position to 4-bit key code
//   col_decode()    : one-cold column pattern to {valid, index}

package calc_pkg;

    localparam logic [3:0] KEY_DIVMOD = 4'ha;
    localparam logic [3:0] KEY_TIMES  = 4'hb;
    localparam logic [3:0] KEY_PM     = 4'hc;
    localparam logic [3:0] KEY_AC     = 4'hd;
    localparam logic [3:0] KEY_ANS    = 4'he;
    localparam logic [3:0] KEY_EQU    = 4'hf;

    typedef enum logic [2:0] {
        SCAN       = 3'd0,
        PRESS_DB   = 3'd1,
        STROBE     = 3'd2,
        HOLD       = 3'd3,
        RELEASE_DB = 3'd4
    } kp_state_t;

    // Keypad legend, row-major, columns 0..3:
    //   1 2 3 a / 4 5 6 b / 7 8 9 c / e 0 f d
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = KEY_DIVMOD;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = KEY_TIMES;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'ha:    code = 4'h9;
            4'hb:    code = KEY_PM;
            4'hc:    code = KEY_ANS;
            4'hd:    code = 4'h0;
            4'he:    code = KEY_EQU;
            default: code = KEY_AC;
        endcase
        return code;
    endfunction

    // Bit 2 set only when exactly one column is pulled low; bits 1:0 give
    // that column. No-key and ghosted patterns both decode as invalid.
    function automatic logic [2:0] col_decode(input logic [3:0] cols);
        logic [2:0] res;
        case (cols)
            4'b1110: res = 3'b100;
            4'b1101: res = 3'b101;
            4'b1011: res = 3'b110;
            4'b0111: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - two-flop synchronizer for the keypad column inputs
//
// Ports:
//   sw_clk   in  1  switch clock
//   rst      in  1  asynchronous active-low reset (outputs idle-high 4'hF)
//   col_raw  in  4  asynchronous column lines from the keypad
//   col_sync out 4  column lines retimed to sw_clk

module keypad_sync (
    input  logic       sw_clk,
    input  logic       rst,
    input  logic [3:0] col_raw,
    output logic [3:0] col_sync
);

    logic [3:0] col_meta;

    // Reset to all-high so the encoder sees "no key" until real samples arrive.
    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col_raw;
            col_sync <= col_meta;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// rtl/keypad_encoder.sv - 4x4 keypad scanner, debouncer and eBCD encoder
//
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-strobe a held key
// after REPEAT_DLY cycles and every REPEAT_DLY/4 cycles after that
// (never for the AC key).
//
// Ports:
//   sw_clk  in  1  switch clock
//   rst     in  1  asynchronous active-low reset
//   col_in  in  4  keypad columns, pulled up; pressed key reads 0
//   row_out out 4  one-cold row drive, active row low
//   eBCD    out 5  {strobe, code[3:0]}; front-end latches code on strobe rise

module keypad_encoder
    import calc_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV     = 16'd1000,
    parameter logic [15:0] DEBOUNCE_CNT = 16'd20000,
    parameter logic [3:0]  STROBE_LEN   = 4'd4,
    parameter logic [23:0] REPEAT_DLY   = 24'd500000
) (
    input  logic       sw_clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [4:0] eBCD
);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif

    logic [3:0]  col_s;

    kp_state_t   state,   state_n;
    logic [1:0]  row,     row_n;
    logic [1:0]  col_idx, col_idx_n;
    logic [3:0]  pat,     pat_n;
    logic [15:0] scan_cnt, scan_cnt_n;
    logic [15:0] deb_cnt,  deb_cnt_n;
    logic [3:0]  ph,      ph_n;
    logic [23:0] rep_cnt, rep_cnt_n;
    logic        repeating, repeating_n;
    logic [3:0]  code_q,  code_n;

    logic [2:0]  col_dec;
    logic [23:0] rep_thr;
    logic [23:0] rep_inc;
    logic        strobe;

    keypad_sync u_sync (
        .sw_clk   (sw_clk),
        .rst      (rst),
        .col_raw  (col_in),
        .col_sync (col_s)
    );

    assign col_dec = col_decode(col_s);

    // First repeat waits the full delay, later ones a quarter of it.
    assign rep_thr = repeating ? (REPEAT_DLY >> 2) : REPEAT_DLY;
    assign rep_inc = (rep_cnt == 24'hFF_FFFF) ? rep_cnt : rep_cnt + 24'd1;

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            state     <= SCAN;
            row       <= 2'd0;
            col_idx   <= 2'd0;
            pat       <= 4'hF;
            scan_cnt  <= 16'd0;
            deb_cnt   <= 16'd0;
            ph        <= 4'd0;
            rep_cnt   <= 24'd0;
            repeating <= 1'b0;
            code_q    <= 4'h0;
        end else begin
            state     <= state_n;
            row       <= row_n;
            col_idx   <= col_idx_n;
            pat       <= pat_n;
            scan_cnt  <= scan_cnt_n;
            deb_cnt   <= deb_cnt_n;
            ph        <= ph_n;
            rep_cnt   <= rep_cnt_n;
            repeating <= repeating_n;
            code_q    <= code_n;
        end
    end

    always_comb begin
        state_n     = state;
        row_n       = row;
        col_idx_n   = col_idx;
        pat_n       = pat;
        scan_cnt_n  = scan_cnt;
        deb_cnt_n   = deb_cnt;
        ph_n        = ph;
        rep_cnt_n   = rep_cnt;
        repeating_n = repeating;
        code_n      = code_q;

        case (state)
            SCAN: begin
                if (scan_cnt >= SCAN_DIV - 16'd1) begin
                    scan_cnt_n = 16'd0;
                    if (col_dec[2]) begin
                        // Single key on this row: freeze the row and debounce it.
                        pat_n     = col_s;
                        col_idx_n = col_dec[1:0];
                        deb_cnt_n = 16'd0;
                        state_n   = PRESS_DB;
                    end else begin
                        row_n = row + 2'd1;
                    end
                end else begin
                    scan_cnt_n = scan_cnt + 16'd1;
                end
            end

            PRESS_DB: begin
                if (col_s == pat) begin
                    if (deb_cnt >= DEBOUNCE_CNT - 16'd1) begin
                        // Code is loaded on entry so it is valid one cycle
                        // ahead of the strobe rise.
                        deb_cnt_n   = DEBOUNCE_CNT;
                        code_n      = key_code(row, col_idx);
                        ph_n        = 4'd0;
                        rep_cnt_n   = 24'd0;
                        repeating_n = 1'b0;
                        state_n     = STROBE;
                    end else begin
                        deb_cnt_n = deb_cnt + 16'd1;
                    end
                end else begin
                    deb_cnt_n  = 16'd0;
                    scan_cnt_n = 16'd0;
                    row_n      = row + 2'd1;
                    state_n    = SCAN;
                end
            end

            STROBE: begin
                rep_cnt_n = rep_inc;
                if (ph >= STROBE_LEN) begin
                    state_n = HOLD;
                end else begin
                    ph_n = ph + 4'd1;
                end
            end

            HOLD: begin
                rep_cnt_n = rep_inc;
                if (col_s == 4'hF) begin
                    deb_cnt_n = 16'd0;
                    state_n   = RELEASE_DB;
                end else if (AUTOREPEAT && (code_q != KEY_AC) &&
                             (rep_cnt >= rep_thr - 24'd1)) begin
                    // rep_cnt restarts on every STROBE entry, so the
                    // rise-to-rise spacing equals rep_thr exactly.
                    ph_n        = 4'd0;
                    rep_cnt_n   = 24'd0;
                    repeating_n = 1'b1;
                    state_n     = STROBE;
                end
            end

            RELEASE_DB: begin
                rep_cnt_n = rep_inc;
                if (col_s == 4'hF) begin
                    if (deb_cnt >= DEBOUNCE_CNT - 16'd1) begin
                        deb_cnt_n  = 16'd0;
                        scan_cnt_n = 16'd0;
                        row_n      = row + 2'd1;
                        state_n    = SCAN;
                    end else begin
                        deb_cnt_n = deb_cnt + 16'd1;
                    end
                end else begin
                    deb_cnt_n = 16'd0;
                    state_n   = HOLD;
                end
            end

            default: begin
                state_n = SCAN;
            end
        endcase
    end

    // Strobe is decoded from registered state so reset clears it at once.
    assign strobe = (state == STROBE) && (ph != 4'd0);

    always_comb begin
        case (row)
            2'd0:    row_out = 4'b1110;
            2'd1:    row_out = 4'b1101;
            2'd2:    row_out = 4'b1011;
            default: row_out = 4'b0111;
        endcase
    end

    assign eBCD = {strobe, code_q};

endmodule

// File: tb/tb_keypad_encoder.sv
// tb/tb_keypad_encoder.sv - randomized self-checking bench for keypad_encoder

module tb_keypad_encoder;

    localparam int SD = 4;
    localparam int DB = 8;
    localparam int SL = 2;
    localparam int RD = 64;

    logic       sw_clk = 1'b0;
    logic       rst    = 1'b0;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [4:0] eBCD;

    logic [3:0] keys [4];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int press_cyc = 0;

    int         rise_t[$];
    int         rise_code[$];
    int         widths[$];
    int         unstable = 0;
    int         cur_w = 0;
    logic       prev_stb = 1'b0;
    logic [3:0] prev_code = 4'h0;

    int key_map [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    keypad_encoder #(
        .SCAN_DIV     (16'd4),
        .DEBOUNCE_CNT (16'd8),
        .STROBE_LEN   (4'd2),
        .REPEAT_DLY   (24'd64)
    ) dut (
        .sw_clk  (sw_clk),
        .rst     (rst),
        .col_in  (col_in),
        .row_out (row_out),
        .eBCD    (eBCD)
    );

    always #5 sw_clk = ~sw_clk;

    always @(posedge sw_clk) cyc <= cyc + 1;

    // Matrix model: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_out[r]) col_in = col_in & ~keys[r];
        end
    end

    // Strobe monitor: rise time, code one cycle before rise, pulse width.
    always @(negedge sw_clk) begin
        if (eBCD[4] && !prev_stb) begin
            rise_t.push_back(cyc);
            rise_code.push_back(int'(prev_code));
            cur_w = 1;
        end else if (eBCD[4]) begin
            cur_w = cur_w + 1;
        end
        if (eBCD[4] && eBCD[3:0] != prev_code) unstable = unstable + 1;
        if (!eBCD[4] && prev_stb) widths.push_back(cur_w);
        prev_stb  = eBCD[4];
        prev_code = eBCD[3:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk = n_chk + 1;
        if (obs === exp_v) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sw_clk);
    endtask

    task automatic clr_mon();
        rise_t.delete();
        rise_code.delete();
        widths.delete();
        unstable = 0;
    endtask

    task automatic key_event(input int r, input int c, input int hold);
        clr_mon();
        keys[r][c] = 1'b1;
        press_cyc  = cyc;
        idle(hold);
        keys[r][c] = 1'b0;
        idle(40);
    endtask

    task automatic expect_single(input string tag, input int code);
        chk({tag, "_count"}, rise_t.size(), 1);
        if (rise_t.size() > 0) chk({tag, "_code"}, rise_code[0], code);
        if (widths.size() > 0) chk({tag, "_width"}, widths[0], SL);
        chk({tag, "_stable"}, unstable, 0);
    endtask

    initial begin
        int lat;
        int changes;
        int got;
        int r;
        int c;
        int hold;
        int long_p;
        logic [3:0] exp_row;
        logic [3:0] prev_row;

        for (int i = 0; i < 4; i++) keys[i] = 4'h0;

        // Reset state, then free-running scan with no keys.
        idle(3);
        chk("rst_row", row_out, 4'hE);
        chk("rst_ebcd", eBCD, 5'h00);
        rst = 1'b1;
        for (int k = 0; k < 40; k++) begin
            exp_row = 4'hF ^ (4'b0001 << ((k / SD) % 4));
            chk("idle_row", row_out, exp_row);
            chk("idle_ebcd", eBCD, 5'h00);
            idle(1);
        end

        // Key "6": one strobe, correct width, code ahead of rise, bounded latency.
        key_event(1, 2, 60);
        expect_single("k6", 6);
        if (rise_t.size() > 0) begin
            lat = rise_t[0] - press_cyc;
            chk("k6_latency_in_range", (lat >= DB + 4 && lat <= 4 * SD + DB + 3), 1);
        end
        chk("k6_code_held", eBCD, 5'h06);

        // Bouncing "a": toggles every 3 cycles, then settles low.
        clr_mon();
        for (int p = 0; p < 8; p++) begin
            keys[0][3] = (p % 2 == 0);
            idle(3);
        end
        keys[0][3] = 1'b1;
        idle(30);
        keys[0][3] = 1'b0;
        idle(40);
        expect_single("bounce", 10);

        // Ghosting on row 2: no strobe and the scan keeps moving.
        clr_mon();
        keys[2] = 4'b0011;
        changes = 0;
        prev_row = row_out;
        for (int k = 0; k < 60; k++) begin
            idle(1);
            if (row_out != prev_row) changes = changes + 1;
            prev_row = row_out;
        end
        keys[2] = 4'h0;
        idle(20);
        chk("ghost_strobes", rise_t.size(), 0);
        chk("ghost_scan_moving", (changes >= 60 / SD - 1), 1);

        // Reset during the first strobe-high cycle of "f".
        keys[3][2] = 1'b1;
        got = 0;
        for (int k = 0; k < 60 && got == 0; k++) begin
            idle(1);
            if (eBCD[4]) got = 1;
        end
        chk("f_strobe_seen", got, 1);
        chk("f_code", eBCD[3:0], 4'hf);
        rst = 1'b0;
        #1;
        chk("rst_mid_ebcd", eBCD, 5'h00);
        chk("rst_mid_row", row_out, 4'hE);
        idle(2);
        rst = 1'b1;
        clr_mon();
        idle(DB + 3);
        chk("post_rst_no_strobe", rise_t.size(), 0);
        keys[3][2] = 1'b0;
        idle(40);

        // Long hold of "c", then "d".
        key_event(2, 3, 200);
`ifdef KEYPAD_AUTOREPEAT_EN
        chk("rep_c_count_ge3", (rise_t.size() >= 3), 1);
        if (rise_t.size() >= 2) chk("rep_c_first_gap", rise_t[1] - rise_t[0], RD);
        for (int i = 2; i < rise_t.size(); i++) chk("rep_c_gap", rise_t[i] - rise_t[i-1], RD / 4);
        for (int i = 0; i < rise_code.size(); i++) chk("rep_c_code", rise_code[i], 12);
`else
        expect_single("hold_c", 12);
`endif
        key_event(3, 3, 200);
        expect_single("hold_d", 13);

        // Random keys: long holds give exactly one strobe, short taps none.
        for (int it = 0; it < 12; it++) begin
            r      = $urandom_range(0, 3);
            c      = $urandom_range(0, 3);
            long_p = $urandom_range(0, 1);
            hold   = long_p ? $urandom_range(30, 60) : $urandom_range(1, 7);
            key_event(r, c, hold);
            if (long_p != 0) expect_single("rnd", key_map[r * 4 + c]);
            else chk("rnd_short_none", rise_t.size(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
